// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
// Module      : data_mem
// Description : Single-port word-addressed data RAM with a registered,
//               write-first read port for the CPU load/store path.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  en,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;

    // Declaration initialiser gives the zeroed power-up image; reset never clears it.
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] r_dout;
    logic [DEPTH_LOG2-1:0] w_index;
    logic                  w_access;
    logic                  w_write;

    assign w_index  = addr[DEPTH_LOG2-1:0];
    assign w_access = rst_n && en;
    assign w_write  = w_access && we;

    generate
        if (ADDR_WIDTH > DEPTH_LOG2) begin : g_alias
            // Upper address bits are deliberately ignored so addresses alias.
            logic w_unused_hi;
            assign w_unused_hi = ^addr[ADDR_WIDTH-1:DEPTH_LOG2];
        end else begin : g_no_alias
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[w_index] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= '0;
        end else if (en) begin
            r_dout <= we ? din : r_mem[w_index];
        end
    end

    assign dout = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_data_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem
// Description : Scoreboard bench for data_mem with a sparse reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DL2   = 10;
    localparam int DEPTH = 1 << DL2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          en = 1'b0;
    logic          we = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;

    data_mem #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH_LOG2 (DL2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .en    (en),
        .we    (we),
        .din   (din),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          edge_n;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t        sb [$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    // Reference model: sparse memory keyed by word index, default zero.
    logic [31:0] ref_mem [int];
    logic [31:0] ref_dout = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: the DUT presents a fresh dout after every edge.
    always @(posedge clk) begin
        #1;
        while (sb.size() > 0 && sb[0].edge_n <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.edge_n != cyc || dout !== e.val) begin
                errors++;
                $display("FAIL %s: edge %0d dout=%h required=%h (at edge %0d)",
                         e.tag, e.edge_n, dout, e.val, cyc);
            end
        end
    end

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        int idx;
        idx = int'(a % DEPTH);
        return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    endfunction

    // Drive one access for the next rising edge and push what dout must be after it.
    task automatic step(input logic e, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
        exp_t x;
        @(negedge clk);
        en   = e;
        we   = w;
        addr = a;
        din  = d;
        if (!rst_n) begin
            ref_dout = '0;
        end else if (e) begin
            if (w) begin
                ref_mem[int'(a % DEPTH)] = d;
                ref_dout = d;
            end else begin
                ref_dout = ref_read(a);
            end
        end
        x.edge_n = cyc + 1;
        x.val    = ref_dout;
        x.tag    = tag;
        sb.push_back(x);
    endtask

    task automatic direct_check(input string tag, input logic [31:0] req);
        checks++;
        if (dout !== req) begin
            errors++;
            $display("FAIL %s: dout=%h required=%h", tag, dout, req);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        direct_check("reset_state", 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        step(1, 1, 32'h0,        32'hA5,       "wr0_writefirst");
        step(1, 0, 32'h0,        32'h0,        "rd0");
        step(1, 1, 32'h101,      32'h3C,       "wr101_writefirst");
        step(1, 0, 32'h101,      32'h0,        "rd101");
        step(1, 0, 32'h0,        32'h0,        "rd0_no_cross");
        step(1, 0, 32'h11,       32'h0,        "rd_unwritten");
        step(0, 1, 32'h0,        32'hFFFFFFFF, "en_gate_hold1");
        step(0, 1, 32'h0,        32'hFFFFFFFF, "en_gate_hold2");
        step(1, 0, 32'h0,        32'h0,        "rd0_after_gate");
        step(1, 1, 32'h401,      32'hDEADBEEF, "wr401_alias");
        step(1, 0, 32'h001,      32'h0,        "rd001_alias");
        step(1, 1, 32'h5,        32'h12345678, "wr5_pre_reset");

        // Asynchronous reset mid-cycle, well clear of any edge.
        @(posedge clk);
        #2;
        en    = 1'b0;
        rst_n = 1'b0;
        #1;
        ref_dout = '0;
        direct_check("async_reset_clear", 32'h0);
        step(1, 1, 32'h5,        32'hFFFF0000, "write_blocked_in_reset");
        step(1, 0, 32'h5,        32'h0,        "read_blocked_in_reset");
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;
        step(1, 0, 32'h5,        32'h0,        "rd5_mem_preserved");
        step(1, 0, 32'h401,      32'h0,        "rd401_mem_preserved");

        // Randomised traffic; a few hot indices with random upper bits force aliasing hits.
        for (int i = 0; i < 400; i++) begin
            logic        re, rw;
            logic [31:0] ra, rd;
            re = ($urandom_range(0, 9) != 0);
            rw = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1)
                ra = {$urandom_range(0, 255) << DL2} | 32'($urandom_range(0, 7));
            else
                ra = $urandom;
            rd = $urandom;
            step(re, rw, ra, rd, "random");
        end

        step(0, 0, 32'h0, 32'h0, "final_idle");
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem.md
Name: data_mem

Overview:
- Single-port synchronous data memory (block-RAM style) for the processor's load/store path.
- Word-addressed: 32-bit write and 32-bit read per access, with a registered read output.
- Sits between the CPU's memory stage and nothing else. No bus protocol; the CPU drives en/we/addr/din directly and samples dout one cycle later.

Parameters:
- DATA_WIDTH, 32, width of din, dout and each memory word.
- ADDR_WIDTH, 32, width of the addr port.
- DEPTH_LOG2, 10, log2 of word count. Default 1024 words; only addr[DEPTH_LOG2-1:0] is used.

Ports:
- clk    input  1           system clock; all state updates on the rising edge.
- rst_n  input  1           asynchronous active-low reset.
- addr   input  ADDR_WIDTH  word address (word index, not byte address).
- en     input  1           access enable; when low, no read or write occurs.
- we     input  1           write enable; qualified by en.
- din    input  DATA_WIDTH  write data.
- dout   output DATA_WIDTH  registered read data.

Behaviour:
- Storage: array of 2^DEPTH_LOG2 words of DATA_WIDTH bits.
  - All words are zero at configuration/simulation start (explicit zero initialisation).
  - Reads of never-written locations return 0, never X.
- Address mapping:
  - Index = addr[DEPTH_LOG2-1:0]; upper address bits are ignored.
  - Out-of-range addresses alias modulo 2^DEPTH_LOG2 (e.g. 0x401 aliases 0x001 at default depth).
- Reset:
  - rst_n low forces dout to 0 immediately (asynchronous), and dout holds 0 while rst_n is low.
  - Memory contents are NOT cleared by reset.
  - Writes are blocked while rst_n is low.
  - Reset deassertion takes effect at the next rising clk edge; no write or read occurs on the edge coinciding with deassertion unless rst_n is already high.
- Write: on a rising edge with en=1 and we=1, mem[index] <= din.
- Read: on a rising edge with en=1 and we=0, dout <= mem[index]. Latency is one cycle; dout is valid after the edge.
- Write-first policy: on a rising edge with en=1 and we=1, dout <= din, so the written value appears on dout the same cycle.
- Idle: en=0 means no memory change and dout holds its previous value, regardless of we.
- Back-to-back: a write at edge N followed by a read of the same address at edge N+1 returns the new data. No hazard cycles.
- dout changes only on clk rising edges or asynchronous reset, never combinationally with addr.
- Full-width writes only; no byte enables.

Test Plan:
- Reset: rst_n=0 mid-cycle with dout=0x12345678 -> dout=0 immediately, before the next clk edge. After release, a read of a previously written location returns its data (memory preserved).
- Write/read address 0: en=1, we=1, addr=0x0, din=0xA5 for one edge; then we=0, addr=0x0 for one edge -> dout=0x000000A5 after the write edge (write-first) and after the read edge.
- Write/read address 0x101: we=1, addr=0x101, din=0x3C; then we=0 read of 0x101 -> dout=0x0000003C. A subsequent read of 0x0 -> 0x000000A5 (no cross-corruption).
- Unwritten location: read addr=0x11 -> dout=0x00000000.
- Enable gating: en=0, we=1, addr=0x0, din=0xFFFFFFFF for 2 edges -> dout unchanged. A later read of 0x0 -> 0xA5.
- Aliasing: write 0xDEADBEEF at addr=0x401 (default depth), read addr=0x001 -> dout=0xDEADBEEF.
